// File: rtl/weight_buffer_core.sv
// Asymmetric weight store: wide word writes, narrow lane reads, self-filling after reset.
// Read latency 2 cycles, one read per cycle; no backpressure, requests during init are dropped.
module weight_buffer_core #(
   parameter int RD_WIDTH      = 16,
   parameter int WR_WIDTH      = 64,
   parameter int RD_ADDR_WIDTH = 7,
   parameter int WR_ADDR_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     write_req,
   input  logic [WR_ADDR_WIDTH-1:0] write_addr,
   input  logic [WR_WIDTH-1:0]      write_data,
   input  logic                     read_req,
   input  logic [RD_ADDR_WIDTH-1:0] read_addr,
   output logic [RD_WIDTH-1:0]      read_data,
   output logic                     read_data_valid,
   output logic                     init_busy
);

   localparam int LSB   = RD_ADDR_WIDTH - WR_ADDR_WIDTH;
   localparam int LANES = WR_WIDTH / RD_WIDTH;
   localparam int DEPTH = 1 << WR_ADDR_WIDTH;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [WR_ADDR_WIDTH-1:0] init_cnt;

   logic [WR_WIDTH-1:0]      mem [DEPTH];
   logic                     mem_we;
   logic [WR_ADDR_WIDTH-1:0] mem_waddr;
   logic [WR_WIDTH-1:0]      mem_wdata;
   logic [WR_WIDTH-1:0]      init_word;
   logic                     rd_accept;

   logic                     s1_vld;
   logic [WR_WIDTH-1:0]      s1_word;
   logic [LSB-1:0]           s1_lane;
   logic [RD_WIDTH-1:0]      lane_dat;

   // State register; the init counter wraps back to zero as the fill completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:  if (&init_cnt) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = ST_INIT;
      endcase
   end

   // Init pattern: every lane holds its own weight address, sized to the lane.
   always_comb begin
      init_word = '0;
      for (int k = 0; k < LANES; k++) begin
         init_word[k*RD_WIDTH +: RD_WIDTH] = RD_WIDTH'({init_cnt, LSB'(k)});
      end
   end

   always_comb begin
      init_busy = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = write_addr;
      mem_wdata = write_data;
      rd_accept = 1'b0;
      case (state)
         ST_INIT: begin
            init_busy = 1'b1;
            mem_we    = !reset;
            mem_waddr = init_cnt;
            mem_wdata = init_word;
         end
         ST_READY: begin
            mem_we    = write_req && !reset;
            rd_accept = read_req && !reset;
         end
         default: begin
            init_busy = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Stage 1 reads the array with non-blocking semantics, so a same-edge write is not seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= rd_accept;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_accept) begin
         s1_word <= mem[read_addr[RD_ADDR_WIDTH-1:LSB]];
         s1_lane <= read_addr[LSB-1:0];
      end
   end

   always_comb begin
      lane_dat = '0;
      for (int k = 0; k < LANES; k++) begin
         if (s1_lane == LSB'(k)) begin
            lane_dat = s1_word[k*RD_WIDTH +: RD_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         read_data       <= '0;
         read_data_valid <= 1'b0;
      end else begin
         read_data_valid <= s1_vld;
         if (s1_vld) begin
            read_data <= lane_dat;
         end
      end
   end

endmodule
